// File: rtl/bram_rmw_writer.sv
// rtl/bram_rmw_writer.sv - masked read-modify-write front end for one BRAM port
//
// Accepts one masked update command at a time and turns it into BRAM port
// activity: a partial mask reads the word, merges and writes it back; an
// all-ones mask writes directly; an all-zero mask is dropped and counted.
//
// Ports:
//   clk, rst            sole clock, synchronous active-high reset
//   s_valid/s_ready     command handshake (accept when both high at posedge)
//   s_addr/s_data/s_mask command word address, new bits, per-bit replace enable
//   m_wr/m_addr/m_din   BRAM write enable, address, write data
//   m_dout              BRAM read data, one cycle after m_addr is sampled
//   busy                high whenever a command is in flight
//   upd_count           BRAM writes issued (wraps)
//   drop_count          all-zero-mask commands dropped (wraps)

module bram_rmw_writer #(
    parameter int DATA = 72,
    parameter int ADDR = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [ADDR-1:0] s_addr,
    input  logic [DATA-1:0] s_data,
    input  logic [DATA-1:0] s_mask,
    output logic            m_wr,
    output logic [ADDR-1:0] m_addr,
    output logic [DATA-1:0] m_din,
    input  logic [DATA-1:0] m_dout,
    output logic            busy,
    output logic [15:0]     upd_count,
    output logic [15:0]     drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    localparam logic [DATA-1:0] MASK_ONES = '1;

    state_t          state_q, state_d;
    logic            m_wr_q, m_wr_d;
    logic [ADDR-1:0] m_addr_q, m_addr_d;
    logic [DATA-1:0] m_din_q, m_din_d;
    logic [DATA-1:0] data_q, data_d;
    logic [DATA-1:0] mask_q, mask_d;
    logic [15:0]     upd_count_q, upd_count_d;
    logic [15:0]     drop_count_q, drop_count_d;

    logic accept;
    logic mask_zero;
    logic mask_full;

    // Gating with rst keeps the block from accepting on any reset edge,
    // including the last one before release.
    assign s_ready   = (state_q == ST_IDLE) && !rst;
    assign accept    = s_valid && s_ready;
    assign mask_zero = (s_mask == '0);
    assign mask_full = (s_mask == MASK_ONES);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            m_wr_q       <= 1'b0;
            m_addr_q     <= '0;
            m_din_q      <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            upd_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            m_wr_q       <= m_wr_d;
            m_addr_q     <= m_addr_d;
            m_din_q      <= m_din_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            upd_count_q  <= upd_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !mask_zero) begin
                    state_d = mask_full ? ST_WR : ST_RD;
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: state_d = ST_WR;
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic: everything holds unless a state acts on it
    always_comb begin
        m_wr_d       = 1'b0;
        m_addr_d     = m_addr_q;
        m_din_d      = m_din_q;
        data_d       = data_q;
        mask_d       = mask_q;
        upd_count_d  = upd_count_q;
        drop_count_d = drop_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (mask_zero) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end else begin
                        m_addr_d = s_addr;
                        data_d   = s_data;
                        mask_d   = s_mask;
                        if (mask_full) begin
                            m_din_d = s_data;
                            m_wr_d  = 1'b1;
                        end
                    end
                end
            end
            ST_RD: begin
                // BRAM samples the read address during this cycle
            end
            ST_WAIT: begin
                // m_dout now carries the old word; merge under the mask
                m_din_d = (m_dout & ~mask_q) | (data_q & mask_q);
                m_wr_d  = 1'b1;
            end
            ST_WR: begin
                upd_count_d = upd_count_q + 16'd1;
            end
            default: begin
            end
        endcase
    end

    assign m_wr       = m_wr_q;
    assign m_addr     = m_addr_q;
    assign m_din      = m_din_q;
    assign busy       = (state_q != ST_IDLE) && !rst;
    assign upd_count  = upd_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_bram_rmw_writer.sv
// tb/tb_bram_rmw_writer.sv - directed self-checking bench for bram_rmw_writer

module tb_bram_rmw_writer;

    localparam int DATA = 72;
    localparam int ADDR = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [ADDR-1:0] s_addr;
    logic [DATA-1:0] s_data;
    logic [DATA-1:0] s_mask;
    logic            m_wr;
    logic [ADDR-1:0] m_addr;
    logic [DATA-1:0] m_din;
    logic [DATA-1:0] m_dout;
    logic            busy;
    logic [15:0]     upd_count;
    logic [15:0]     drop_count;

    int checks = 0;
    int errors = 0;

    // BRAM model with a bench-side preload port
    logic [DATA-1:0] mem [0:(1<<ADDR)-1];
    logic            pl_we = 1'b0;
    logic [ADDR-1:0] pl_addr = '0;
    logic [DATA-1:0] pl_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (m_wr) mem[m_addr] <= m_din;
        m_dout <= mem[m_addr];
    end

    bram_rmw_writer #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_addr(s_addr), .s_data(s_data), .s_mask(s_mask),
        .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout),
        .busy(busy), .upd_count(upd_count), .drop_count(drop_count)
    );

    task automatic preload(input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; s_valid = 1'b1; s_addr = 10'h001; s_data = 72'h11; s_mask = '1;
        step; step;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (m_wr !== 1'b0) begin errors++; $display("FAIL reset_m_wr: got %b expected 0", m_wr); end
        checks++; if (m_addr !== 10'h000) begin errors++; $display("FAIL reset_m_addr: got %h expected 000", m_addr); end
        checks++; if (m_din !== 72'h0) begin errors++; $display("FAIL reset_m_din: got %h expected 0", m_din); end
        checks++; if (upd_count !== 16'h0 || drop_count !== 16'h0) begin errors++; $display("FAIL reset_counts: got %h/%h expected 0000/0000", upd_count, drop_count); end
        rst = 1'b0; s_valid = 1'b0;
        step;
        checks++; if (busy !== 1'b0 || m_wr !== 1'b0) begin errors++; $display("FAIL reset_no_accept: busy=%b m_wr=%b expected 0/0", busy, m_wr); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", s_ready); end
    endtask

    task automatic test_full_write;
        @(negedge clk);
        s_valid = 1'b1; s_addr = 10'h005; s_data = 72'hAB; s_mask = '1;
        step;
        s_valid = 1'b0;
        checks++; if (m_wr !== 1'b1) begin errors++; $display("FAIL full_m_wr: got %b expected 1", m_wr); end
        checks++; if (m_addr !== 10'h005) begin errors++; $display("FAIL full_m_addr: got %h expected 005", m_addr); end
        checks++; if (m_din !== 72'hAB) begin errors++; $display("FAIL full_m_din: got %h expected ab", m_din); end
        checks++; if (busy !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL full_busy: busy=%b s_ready=%b expected 1/0", busy, s_ready); end
        step;
        checks++; if (m_wr !== 1'b0) begin errors++; $display("FAIL full_strobe_len: got %b expected 0", m_wr); end
        checks++; if (upd_count !== 16'd1) begin errors++; $display("FAIL full_upd_count: got %0d expected 1", upd_count); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_again: got %b expected 1", s_ready); end
        checks++; if (mem[5] !== 72'hAB) begin errors++; $display("FAIL full_mem: got %h expected ab", mem[5]); end
    endtask

    task automatic test_partial_and_ignore;
        preload(10'h010, 72'hFF00);
        preload(10'h3FF, 72'h77);
        @(negedge clk);
        s_valid = 1'b1; s_addr = 10'h010; s_data = 72'h1234; s_mask = 72'h00FF;
        step;
        // keep s_valid high with a different command while busy: must be ignored
        s_addr = 10'h3FF; s_data = '1; s_mask = '1;
        checks++; if (m_wr !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL part_rd: m_wr=%b busy=%b expected 0/1", m_wr, busy); end
        step;
        checks++; if (m_wr !== 1'b0 || m_addr !== 10'h010) begin errors++; $display("FAIL part_wait: m_wr=%b m_addr=%h expected 0/010", m_wr, m_addr); end
        step;
        s_valid = 1'b0;
        checks++; if (m_wr !== 1'b1) begin errors++; $display("FAIL part_m_wr: got %b expected 1", m_wr); end
        checks++; if (m_din !== 72'hFF34) begin errors++; $display("FAIL part_m_din: got %h expected ff34", m_din); end
        checks++; if (m_addr !== 10'h010) begin errors++; $display("FAIL part_m_addr: got %h expected 010", m_addr); end
        step;
        checks++; if (m_wr !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL part_done: m_wr=%b s_ready=%b expected 0/1", m_wr, s_ready); end
        checks++; if (upd_count !== 16'd2) begin errors++; $display("FAIL part_upd_count: got %0d expected 2", upd_count); end
        checks++; if (mem[16] !== 72'hFF34) begin errors++; $display("FAIL part_mem: got %h expected ff34", mem[16]); end
        checks++; if (mem[10'h3FF] !== 72'h77) begin errors++; $display("FAIL ignore_mem: got %h expected 77", mem[10'h3FF]); end
        checks++; if (m_din !== 72'hFF34) begin errors++; $display("FAIL part_din_hold: got %h expected ff34", m_din); end
    endtask

    task automatic test_drop;
        @(negedge clk);
        s_valid = 1'b1; s_addr = 10'h3FF; s_data = 72'hFFFF; s_mask = '0;
        step;
        s_valid = 1'b0;
        checks++; if (m_wr !== 1'b0) begin errors++; $display("FAIL drop_m_wr: got %b expected 0", m_wr); end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d expected 1", drop_count); end
        checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL drop_ready: s_ready=%b busy=%b expected 1/0", s_ready, busy); end
        checks++; if (m_addr !== 10'h010) begin errors++; $display("FAIL drop_addr_hold: got %h expected 010", m_addr); end
        step;
        checks++; if (m_wr !== 1'b0 || upd_count !== 16'd2) begin errors++; $display("FAIL drop_no_write: m_wr=%b upd=%0d expected 0/2", m_wr, upd_count); end
    endtask

    task automatic test_back_to_back;
        preload(10'h020, 72'h00);
        @(negedge clk);
        s_valid = 1'b1; s_addr = 10'h020; s_data = 72'hAA; s_mask = 72'h0F;
        step;
        s_data = 72'h55; s_mask = 72'hF0;
        step; step;
        checks++; if (m_wr !== 1'b1 || m_din !== 72'h0A) begin errors++; $display("FAIL b2b_first: m_wr=%b m_din=%h expected 1/0a", m_wr, m_din); end
        step;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", s_ready); end
        step;
        s_valid = 1'b0;
        checks++; if (busy !== 1'b1 || m_wr !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: busy=%b m_wr=%b expected 1/0", busy, m_wr); end
        step; step;
        checks++; if (m_wr !== 1'b1 || m_din !== 72'h5A) begin errors++; $display("FAIL b2b_second: m_wr=%b m_din=%h expected 1/5a", m_wr, m_din); end
        step;
        checks++; if (mem[10'h020] !== 72'h5A) begin errors++; $display("FAIL b2b_mem: got %h expected 5a", mem[10'h020]); end
        checks++; if (upd_count !== 16'd4) begin errors++; $display("FAIL b2b_upd_count: got %0d expected 4", upd_count); end
    endtask

    task automatic test_reset_mid;
        preload(10'h030, 72'hF0);
        @(negedge clk);
        s_valid = 1'b1; s_addr = 10'h030; s_data = 72'h0F; s_mask = 72'h0F;
        step;
        s_valid = 1'b0;
        step;
        rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_during: s_ready=%b busy=%b expected 0/0", s_ready, busy); end
        step;
        checks++; if (m_wr !== 1'b0) begin errors++; $display("FAIL rstmid_m_wr: got %b expected 0", m_wr); end
        rst = 1'b0;
        step;
        checks++; if (s_ready !== 1'b1 || m_wr !== 1'b0) begin errors++; $display("FAIL rstmid_release: s_ready=%b m_wr=%b expected 1/0", s_ready, m_wr); end
        step;
        checks++; if (upd_count !== 16'd0 || m_wr !== 1'b0) begin errors++; $display("FAIL rstmid_upd: upd=%0d m_wr=%b expected 0/0", upd_count, m_wr); end
        checks++; if (mem[10'h030] !== 72'hF0) begin errors++; $display("FAIL rstmid_mem: got %h expected f0", mem[10'h030]); end
    endtask

    task automatic test_wrap;
        force dut.upd_count_q = 16'hFFFF;
        step;
        release dut.upd_count_q;
        step;
        checks++; if (upd_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", upd_count); end
        @(negedge clk);
        s_valid = 1'b1; s_addr = 10'h001; s_data = 72'h99; s_mask = '1;
        step;
        s_valid = 1'b0;
        step;
        checks++; if (upd_count !== 16'h0000) begin errors++; $display("FAIL wrap_upd_count: got %h expected 0000", upd_count); end
        checks++; if (mem[1] !== 72'h99) begin errors++; $display("FAIL wrap_mem: got %h expected 99", mem[1]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_data = '0; s_mask = '0;
        test_reset;
        test_full_write;
        test_partial_and_ignore;
        test_drop;
        test_back_to_back;
        test_reset_mid;
        test_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
